// File: rtl/serial_receiver.sv
// ============================================================================
//  Module   : serial_receiver
//  Purpose  : 8N1 UART receiver with mid-bit sampling, glitch rejection and
//             framing-error/break detection.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module serial_receiver #(
   parameter int pClockFrequency = 24000000,
   parameter int pBaudRate       = 4000000
) (
   input  logic       iClock,
   input  logic       inReset,
   input  logic       iRxd,
   output logic [7:0] oData,
   output logic       oReceived,
   output logic       oFrameError,
   output logic       oBusy
);

   localparam int C_BIT_TICKS  = pClockFrequency / pBaudRate;
   localparam int C_HALF_TICKS = C_BIT_TICKS / 2;
   localparam int C_TIMER_W    = $clog2(C_BIT_TICKS);
   localparam logic [C_TIMER_W-1:0] C_BIT_LAST  = C_TIMER_W'(C_BIT_TICKS - 1);
   localparam logic [C_TIMER_W-1:0] C_HALF_LAST = C_TIMER_W'(C_HALF_TICKS - 1);

   typedef enum logic [2:0] {
      stIdle     = 3'd0,
      stStartBit = 3'd1,
      stDataBit  = 3'd2,
      stStopBit  = 3'd3,
      stWaitIdle = 3'd4
   } state_t;

   state_t                 r_state,   w_stateNext;
   logic [C_TIMER_W-1:0]   r_timer,   w_timerNext;
   logic [2:0]             r_bitIdx,  w_bitIdxNext;
   logic [7:0]             r_shift,   w_shiftNext;
   logic [7:0]             w_dataNext;
   logic                   w_receivedNext;
   logic                   w_frameErrorNext;
   logic                   r_rxMeta;
   logic                   r_rxs;

   // Synchronizer presets to idle-high so reset never looks like a start bit
   always_ff @(posedge iClock) begin
      if (!inReset) begin
         r_rxMeta <= 1'b1;
         r_rxs    <= 1'b1;
      end else begin
         r_rxMeta <= iRxd;
         r_rxs    <= r_rxMeta;
      end
   end

   always_ff @(posedge iClock) begin
      if (!inReset) begin
         r_state     <= stIdle;
         r_timer     <= '0;
         r_bitIdx    <= '0;
         r_shift     <= '0;
         oData       <= '0;
         oReceived   <= 1'b0;
         oFrameError <= 1'b0;
      end else begin
         r_state     <= w_stateNext;
         r_timer     <= w_timerNext;
         r_bitIdx    <= w_bitIdxNext;
         r_shift     <= w_shiftNext;
         oData       <= w_dataNext;
         oReceived   <= w_receivedNext;
         oFrameError <= w_frameErrorNext;
      end
   end

   always_comb begin
      w_stateNext      = r_state;
      w_timerNext      = r_timer + 1'b1;
      w_bitIdxNext     = r_bitIdx;
      w_shiftNext      = r_shift;
      w_dataNext       = oData;
      w_receivedNext   = 1'b0;
      w_frameErrorNext = 1'b0;

      case (r_state)
         stIdle: begin
            w_timerNext  = '0;
            w_bitIdxNext = '0;
            if (!r_rxs) begin
               w_stateNext = stStartBit;
            end
         end

         stStartBit: begin
            if (r_timer == C_HALF_LAST) begin
               w_timerNext = '0;
               w_stateNext = r_rxs ? stIdle : stDataBit;
            end
         end

         stDataBit: begin
            if (r_timer == C_BIT_LAST) begin
               w_timerNext  = '0;
               w_shiftNext  = {r_rxs, r_shift[7:1]};
               w_bitIdxNext = r_bitIdx + 1'b1;
               if (r_bitIdx == 3'd7) begin
                  w_stateNext = stStopBit;
               end
            end
         end

         stStopBit: begin
            if (r_timer == C_BIT_LAST) begin
               w_timerNext = '0;
               if (r_rxs) begin
                  w_dataNext     = r_shift;
                  w_receivedNext = 1'b1;
                  w_stateNext    = stIdle;
               end else begin
                  w_frameErrorNext = 1'b1;
                  w_stateNext      = stWaitIdle;
               end
            end
         end

         stWaitIdle: begin
            w_timerNext = '0;
            if (r_rxs) begin
               w_stateNext = stIdle;
            end
         end

         default: begin
            w_timerNext = '0;
            w_stateNext = stIdle;
         end
      endcase
   end

   assign oBusy = (r_state != stIdle);

endmodule

`default_nettype wire

// File: tb/tb_serial_receiver.sv
// ============================================================================
//  Module   : tb_serial_receiver
//  Purpose  : Directed, table-driven bench for serial_receiver (T=6, H=3).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_receiver;

   localparam int C_BIT = 6;

   logic       iClock = 1'b0;
   logic       inReset;
   logic       iRxd;
   logic [7:0] oData;
   logic       oReceived;
   logic       oFrameError;
   logic       oBusy;

   serial_receiver #(
      .pClockFrequency(24000000),
      .pBaudRate      (4000000)
   ) dut (
      .iClock     (iClock),
      .inReset    (inReset),
      .iRxd       (iRxd),
      .oData      (oData),
      .oReceived  (oReceived),
      .oFrameError(oFrameError),
      .oBusy      (oBusy)
   );

   always #5 iClock = ~iClock;

   typedef struct {
      int         cyc;
      logic       rec;
      logic       err;
      logic [7:0] data;
   } pulse_t;

   typedef struct {
      logic [7:0] data;
      logic       stopBit;
      logic       expRec;
      logic       expErr;
      logic [7:0] expData;
   } vec_t;

   int     nTests = 0;
   int     nFail  = 0;
   int     cyc    = 0;
   logic   bothSeen = 1'b0;
   pulse_t pulses[$];

   always @(posedge iClock) cyc <= cyc + 1;

   // Pulse monitor; a pulse's cycle is the edge count since the frame's edge 0
   always @(negedge iClock) begin
      if (oReceived || oFrameError) begin
         pulses.push_back('{cyc, oReceived, oFrameError, oData});
      end
      if (oReceived && oFrameError) bothSeen = 1'b1;
   end

   task automatic check(input string name, input int act, input int exp);
      nTests++;
      if (act != exp) begin
         nFail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Called right after a negedge; returns after a full 10-bit frame
   task automatic sendFrame(input logic [7:0] b, input logic stopBit);
      iRxd = 1'b0;
      repeat (C_BIT) @(negedge iClock);
      for (int i = 0; i < 8; i++) begin
         iRxd = b[i];
         repeat (C_BIT) @(negedge iClock);
      end
      iRxd = stopBit;
      repeat (C_BIT) @(negedge iClock);
   endtask

   vec_t vecs[5];

   initial begin
      int start;
      int busyCnt;

      vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b0, 8'hA5};
      vecs[1] = '{8'h55, 1'b0, 1'b0, 1'b1, 8'hA5};
      vecs[2] = '{8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
      vecs[3] = '{8'hFF, 1'b1, 1'b1, 1'b0, 8'hFF};
      vecs[4] = '{8'h3C, 1'b0, 1'b0, 1'b1, 8'hFF};

      iRxd    = 1'b1;
      inReset = 1'b0;
      repeat (3) @(negedge iClock);
      check("reset_data",  oData,       8'h00);
      check("reset_rec",   oReceived,   0);
      check("reset_err",   oFrameError, 0);
      check("reset_busy",  oBusy,       0);
      inReset = 1'b1;
      repeat (5) @(negedge iClock);

      // Single frames separated by idle time
      for (int v = 0; v < 5; v++) begin
         pulses.delete();
         start = cyc;
         sendFrame(vecs[v].data, vecs[v].stopBit);
         iRxd = 1'b1;
         repeat (20) @(negedge iClock);
         check($sformatf("vec%0d_npulse", v), pulses.size(), 1);
         if (pulses.size() >= 1) begin
            check($sformatf("vec%0d_latency", v), pulses[0].cyc - start, 60);
            check($sformatf("vec%0d_rec", v), pulses[0].rec, vecs[v].expRec);
            check($sformatf("vec%0d_err", v), pulses[0].err, vecs[v].expErr);
         end
         check($sformatf("vec%0d_data", v), oData, vecs[v].expData);
         check($sformatf("vec%0d_idle", v), oBusy, 0);
      end

      // Back-to-back frames, no idle gap
      pulses.delete();
      start = cyc;
      sendFrame(8'h00, 1'b1);
      sendFrame(8'hFF, 1'b1);
      sendFrame(8'h3C, 1'b1);
      iRxd = 1'b1;
      repeat (20) @(negedge iClock);
      check("b2b_npulse", pulses.size(), 3);
      if (pulses.size() == 3) begin
         check("b2b_lat0",  pulses[0].cyc - start, 60);
         check("b2b_lat1",  pulses[1].cyc - start, 120);
         check("b2b_lat2",  pulses[2].cyc - start, 180);
         check("b2b_data0", pulses[0].data, 8'h00);
         check("b2b_data1", pulses[1].data, 8'hFF);
         check("b2b_data2", pulses[2].data, 8'h3C);
         check("b2b_rec2",  pulses[2].rec, 1);
      end

      // Two-cycle glitch must be rejected
      pulses.delete();
      busyCnt = 0;
      iRxd = 1'b0;
      repeat (2) @(negedge iClock);
      iRxd = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge iClock);
         if (oBusy) busyCnt++;
      end
      nTests++;
      if (busyCnt < 1 || busyCnt > 5) begin
         nFail++;
         $display("FAIL glitch_busy: busy for %0d cycles, expected 1..5", busyCnt);
      end
      check("glitch_npulse", pulses.size(), 0);
      check("glitch_data",   oData, 8'h3C);

      // Bad stop bit followed by a long break
      pulses.delete();
      start = cyc;
      sendFrame(8'h55, 1'b0);
      repeat (100) @(negedge iClock);
      check("break_busy_low", oBusy, 1);
      iRxd = 1'b1;
      busyCnt = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge iClock);
         if (oBusy) busyCnt++;
      end
      check("break_busy_cycles", busyCnt, 2);
      check("break_npulse", pulses.size(), 1);
      if (pulses.size() >= 1) begin
         check("break_latency", pulses[0].cyc - start, 60);
         check("break_err",     pulses[0].err, 1);
      end
      check("break_data", oData, 8'h3C);

      // Reset pulse during data bit 4 aborts the frame
      pulses.delete();
      iRxd = 1'b0;
      repeat (C_BIT) @(negedge iClock);
      for (int i = 0; i < 4; i++) repeat (C_BIT) @(negedge iClock);
      repeat (3) @(negedge iClock);
      check("rst_busy_before", oBusy, 1);
      inReset = 1'b0;
      iRxd    = 1'b1;
      @(negedge iClock);
      check("rst_data", oData,       8'h00);
      check("rst_rec",  oReceived,   0);
      check("rst_err",  oFrameError, 0);
      check("rst_busy", oBusy,       0);
      inReset = 1'b1;
      repeat (80) @(negedge iClock);
      check("rst_npulse", pulses.size(), 0);

      pulses.delete();
      start = cyc;
      sendFrame(8'h81, 1'b1);
      repeat (20) @(negedge iClock);
      check("post_rst_npulse", pulses.size(), 1);
      if (pulses.size() >= 1) begin
         check("post_rst_latency", pulses[0].cyc - start, 60);
         check("post_rst_rec",     pulses[0].rec, 1);
      end
      check("post_rst_data", oData, 8'h81);

      check("never_both", bothSeen, 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

`default_nettype wire
